// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state, transaction owner and the
// command word presented to the memory on a grant cycle.
package mem_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/wait_timer.sv
// Counts cycles spent waiting for a memory ack; tc_o is combinational in the cycle the count
// reaches TIMEOUT. No backpressure: the owner loads it on a grant and clears it on completion.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loading with 1 makes the count equal the number of WAIT cycles seen so far, current included.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(1);
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_TC)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == CNT_TC);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter between fetch and load/store for one memory port; grant is
// same-cycle in IDLE, rvalid is same-cycle with mem_ack_i. Requesters hold their request until granted.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 3,
  parameter int TIMEOUT      = 15
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  input  logic              flush_i,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          drop_q, drop_d;
  logic [SW-1:0] streak_q, streak_d;

  mem_cmd_t cmd;
  logic     f_elig;
  logic     tmr_load, tmr_clr, tmr_en, tmr_tc;

  assign f_elig = f_req_i & ~flush_i;
  assign tmr_en = (state_q == WAIT);

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n_i(rst_n_i),
    .load_i (tmr_load),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    drop_d     = drop_q;
    streak_d   = streak_q;
    cmd        = '0;
    f_gnt_o    = 1'b0;
    d_gnt_o    = 1'b0;
    mem_req_o  = 1'b0;
    f_rvalid_o = 1'b0;
    d_rvalid_o = 1'b0;
    f_rdata_o  = '0;
    d_rdata_o  = '0;
    err_o      = 1'b0;
    tmr_load   = 1'b0;
    tmr_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        // Data has priority until it has won MAX_D_STREAK times in a row over a waiting fetch.
        if (d_req_i && !(f_elig && (streak_q == STREAK_MAX))) begin
          d_gnt_o   = 1'b1;
          mem_req_o = 1'b1;
          cmd.we    = d_we_i;
          cmd.addr  = d_addr_i;
          cmd.wdata = d_wdata_i;
          owner_d   = OWN_D;
          state_d   = WAIT;
          tmr_load  = 1'b1;
          if (!f_elig) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (f_elig) begin
          f_gnt_o   = 1'b1;
          mem_req_o = 1'b1;
          cmd.addr  = f_addr_i;
          owner_d   = OWN_F;
          state_d   = WAIT;
          tmr_load  = 1'b1;
          streak_d  = '0;
        end
      end

      WAIT: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          tmr_clr = 1'b1;
          if (owner_q == OWN_D) begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = mem_rdata_i;
          end else if (!drop_q && !flush_i) begin
            f_rvalid_o = 1'b1;
            f_rdata_o  = mem_rdata_i;
          end
        end else if (tmr_tc) begin
          err_o   = 1'b1;
          state_d = IDLE;
          drop_d  = 1'b0;
          tmr_clr = 1'b1;
        end else if ((owner_q == OWN_F) && flush_i) begin
          drop_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_we_o    = cmd.we;
  assign mem_addr_o  = cmd.addr;
  assign mem_wdata_o = cmd.wdata;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      owner_q  <= OWN_F;
      drop_q   <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      drop_q   <= drop_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected events with their cycle number,
// a negedge monitor pops and compares every grant, rvalid, error and stray strobe it sees.
module tb_mem_port_arbiter;

  localparam int K_FG  = 0;
  localparam int K_DG  = 1;
  localparam int K_FR  = 2;
  localparam int K_DR  = 3;
  localparam int K_ERR = 4;
  localparam int K_STB = 5;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] addr;
    logic       we;
    logic [7:0] dat;
    logic       stb;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       f_req, flush, d_req, d_we, mem_ack;
  logic [7:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic       f_gnt_o, f_rvalid_o, d_gnt_o, d_rvalid_o;
  logic       mem_req_o, mem_we_o, err_o;
  logic [7:0] f_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  bit  order_f[8];

  mem_port_arbiter #(
    .MAX_D_STREAK(3),
    .TIMEOUT     (15)
  ) dut (
    .clk        (clk),
    .rst_n_i    (rst_n),
    .f_req_i    (f_req),
    .f_addr_i   (f_addr),
    .f_gnt_o    (f_gnt_o),
    .f_rvalid_o (f_rvalid_o),
    .f_rdata_o  (f_rdata_o),
    .flush_i    (flush),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_FG:    return "f_grant";
      K_DG:    return "d_grant";
      K_FR:    return "f_rvalid";
      K_DR:    return "d_rvalid";
      K_ERR:   return "err";
      default: return "stray_mem_req";
    endcase
  endfunction

  function automatic ev_t mk(input int c, input int k, input logic [7:0] a, input logic w,
                             input logic [7:0] d, input logic s);
    ev_t e;
    e.cyc = c; e.kind = k; e.addr = a; e.we = w; e.dat = d; e.stb = s;
    return e;
  endfunction

  task automatic exp_fg(input logic [7:0] a);
    exp_q.push_back(mk(cyc, K_FG, a, 1'b0, 8'h00, 1'b1));
  endtask

  task automatic exp_dg(input logic w, input logic [7:0] a, input logic [7:0] wd);
    exp_q.push_back(mk(cyc, K_DG, a, w, wd, 1'b1));
  endtask

  task automatic exp_rv(input int k, input logic [7:0] d);
    exp_q.push_back(mk(cyc, k, 8'h00, 1'b0, d, 1'b0));
  endtask

  task automatic compare_ev(input ev_t o);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected at cycle %0d: addr=%h we=%b dat=%h stb=%b, required no event",
               kname(o.kind), o.cyc, o.addr, o.we, o.dat, o.stb);
    end else begin
      e = exp_q.pop_front();
      if (o.kind != e.kind || o.cyc != e.cyc || o.addr !== e.addr || o.we !== e.we ||
          o.dat !== e.dat || o.stb !== e.stb) begin
        n_fail++;
        $display("FAIL %s: got %s@%0d addr=%h we=%b dat=%h stb=%b, required %s@%0d addr=%h we=%b dat=%h stb=%b",
                 kname(e.kind), kname(o.kind), o.cyc, o.addr, o.we, o.dat, o.stb,
                 kname(e.kind), e.cyc, e.addr, e.we, e.dat, e.stb);
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    ev_t m;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      m = exp_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s missing: required at cycle %0d, not seen by cycle %0d", kname(m.kind), m.cyc, cyc);
    end
    if (f_gnt_o)    compare_ev(mk(cyc, K_FG, mem_addr_o, mem_we_o, mem_wdata_o, mem_req_o));
    if (d_gnt_o)    compare_ev(mk(cyc, K_DG, mem_addr_o, mem_we_o, mem_wdata_o, mem_req_o));
    if (f_rvalid_o) compare_ev(mk(cyc, K_FR, 8'h00, 1'b0, f_rdata_o, mem_req_o));
    if (d_rvalid_o) compare_ev(mk(cyc, K_DR, 8'h00, 1'b0, d_rdata_o, mem_req_o));
    if (err_o)      compare_ev(mk(cyc, K_ERR, 8'h00, 1'b0, 8'h00, mem_req_o));
    if (mem_req_o && !f_gnt_o && !d_gnt_o)
      compare_ev(mk(cyc, K_STB, mem_addr_o, mem_we_o, mem_wdata_o, mem_req_o));
  end

  task automatic check_zero(input string name);
    logic [38:0] v;
    v = {f_gnt_o, f_rvalid_o, f_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
         mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o};
    n_chk++;
    if (v !== 39'd0) begin
      n_fail++;
      $display("FAIL %s: outputs=%h, required all zero", name, v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [7:0] a, input int lat, input logic [7:0] rd);
    f_req = 1'b1; f_addr = a;
    exp_fg(a);
    step();
    f_req = 1'b0; f_addr = 8'h00;
    repeat (lat - 1) step();
    mem_ack = 1'b1; mem_rdata = rd;
    exp_rv(K_FR, rd);
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;
  endtask

  task automatic do_data(input logic w, input logic [7:0] a, input logic [7:0] wd, input int lat,
                         input logic [7:0] rd);
    d_req = 1'b1; d_we = w; d_addr = a; d_wdata = wd;
    exp_dg(w, a, wd);
    step();
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
    repeat (lat - 1) step();
    mem_ack = 1'b1; mem_rdata = rd;
    exp_rv(K_DR, rd);
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;
  endtask

  // Both requesters held; order_f[i] says whether grant i should go to fetch.
  task automatic both_held(input int n, input logic [7:0] fa, input logic [7:0] da, input logic [7:0] rd0);
    f_req = 1'b1; f_addr = fa; d_req = 1'b1; d_addr = da; d_we = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (order_f[i]) exp_fg(fa);
      else            exp_dg(1'b0, da, 8'h00);
      step();
      mem_ack = 1'b1; mem_rdata = rd0 + 8'(i);
      exp_rv(order_f[i] ? K_FR : K_DR, rd0 + 8'(i));
      if (i == n - 1) begin
        f_req = 1'b0; d_req = 1'b0;
      end
      step();
      mem_ack = 1'b0; mem_rdata = 8'h00;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    f_req = 1'b0; f_addr = 8'h00; flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    order_f[0] = 1'b0; order_f[1] = 1'b0; order_f[2] = 1'b0; order_f[3] = 1'b1;
    order_f[4] = 1'b0; order_f[5] = 1'b0; order_f[6] = 1'b0; order_f[7] = 1'b1;

    #2 check_zero("reset_state");
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    step();

    // Lone fetch, ack two cycles after grant
    do_fetch(8'h10, 2, 8'hA5);

    // Ack while IDLE must be ignored
    mem_ack = 1'b1; mem_rdata = 8'h5F;
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;

    // Contention: D,D,D,F,D,D,D,F
    both_held(8, 8'h40, 8'h50, 8'h80);

    // Fetch flushed one cycle after grant: ack data discarded
    f_req = 1'b1; f_addr = 8'h22; exp_fg(8'h22);
    step();
    f_req = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    do_fetch(8'h24, 1, 8'h5A);

    // Flush coinciding with the ack also discards the fetch data
    f_req = 1'b1; f_addr = 8'h26; exp_fg(8'h26);
    step();
    f_req = 1'b0;
    step();
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h33;
    step();
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;

    // Data access is never dropped by flush
    d_req = 1'b1; d_addr = 8'h28; exp_dg(1'b0, 8'h28, 8'h00);
    step();
    d_req = 1'b0; d_addr = 8'h00; flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 8'hC4; exp_rv(K_DR, 8'hC4);
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;

    // Flush with a lone fetch request in IDLE blocks the grant for that cycle only
    f_req = 1'b1; f_addr = 8'h2A; flush = 1'b1;
    step();
    flush = 1'b0; exp_fg(8'h2A);
    step();
    f_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h12; exp_rv(K_FR, 8'h12);
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;

    // Data write
    do_data(1'b1, 8'h20, 8'h3C, 2, 8'h00);

    // Timeout after 15 WAIT cycles; pending data request granted the next cycle
    f_req = 1'b1; f_addr = 8'h30; exp_fg(8'h30);
    step();
    f_req = 1'b0; d_req = 1'b1; d_addr = 8'h60;
    repeat (14) step();
    exp_rv(K_ERR, 8'h00);
    step();
    exp_dg(1'b0, 8'h60, 8'h00);
    step();
    d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h99; exp_rv(K_DR, 8'h99);
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;

    // Ack on the timeout cycle wins
    f_req = 1'b1; f_addr = 8'h32; exp_fg(8'h32);
    step();
    f_req = 1'b0;
    repeat (14) step();
    mem_ack = 1'b1; mem_rdata = 8'h6B; exp_rv(K_FR, 8'h6B);
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;

    // Build streak to 3, then reset in the middle of the third data WAIT
    f_req = 1'b1; f_addr = 8'h41; d_req = 1'b1; d_addr = 8'h51;
    for (int i = 0; i < 2; i++) begin
      exp_dg(1'b0, 8'h51, 8'h00);
      step();
      mem_ack = 1'b1; mem_rdata = 8'hB0 + 8'(i); exp_rv(K_DR, 8'hB0 + 8'(i));
      step();
      mem_ack = 1'b0; mem_rdata = 8'h00;
    end
    exp_dg(1'b0, 8'h51, 8'h00);
    step();
    f_req = 1'b0; d_req = 1'b0; rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hFF;
    #1 check_zero("reset_mid_wait");
    step();
    check_zero("reset_hold");
    step();
    rst_n = 1'b1;
    #1 check_zero("late_ack_after_release");
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;

    // Streak cleared by reset: data wins three times before fetch
    both_held(4, 8'h42, 8'h52, 8'hD0);

    repeat (3) step();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL end_of_run_queue: %0d events outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
